md_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the 128 x 32-bit data memory.
- Shares the memory's single ADR/DIN/W/R/DOUT port between requester 0 (CPU load/store stage) and requester 1 (debug/loader port).
- Uses round-robin arbitration and drives every memory control line from registers, so W and R are never asserted while the address is changing.
- Returns read data registered, with a one-cycle valid pulse per transaction.

---
 rtl/md_arbiter.sv | 164 ++++++++++++++++
 tb/tb_md_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_arbiter.sv
// Round-robin two-port arbiter/sequencer for the 128 x 32 data memory.
// All memory controls and requester responses are registered.
module md_arbiter #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_valid,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_err,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_valid,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_err,
    output logic [AW-1:0] md_adr,
    output logic [DW-1:0] md_din,
    output logic          md_w,
    output logic          md_r,
    input  logic [DW-1:0] md_dout
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]    state, state_n;
    logic          last, last_n;
    logic          sel, sel_n;
    logic          we_q, we_n;
    logic          err_q, err_n;
    logic          gnt0_n, gnt1_n, valid0_n, valid1_n, perr0_n, perr1_n;
    logic [DW-1:0] rdata0_n, rdata1_n, din_n;
    logic [AW-1:0] adr_n;
    logic          w_n, r_n;

    // Candidate request: on a tie the port that was not served last wins.
    logic          pick_c;
    logic          pick_we_c;
    logic [AW-1:0] pick_addr_c;
    logic [DW-1:0] pick_wdata_c;
    logic          in_range_c;
    logic [DW-1:0] cap_c;

    assign pick_c       = (p0_req & p1_req) ? ~last : p1_req;
    assign pick_we_c    = pick_c ? p1_we    : p0_we;
    assign pick_addr_c  = pick_c ? p1_addr  : p0_addr;
    assign pick_wdata_c = pick_c ? p1_wdata : p0_wdata;
    assign in_range_c   = pick_addr_c < AW'(DEPTH);
    assign cap_c        = (~we_q & ~err_q) ? md_dout : '0;

    // Next-state and next-output logic.
    always_comb begin
        state_n  = state;
        last_n   = last;
        sel_n    = sel;
        we_n     = we_q;
        err_n    = err_q;
        gnt0_n   = 1'b0;
        gnt1_n   = 1'b0;
        valid0_n = 1'b0;
        valid1_n = 1'b0;
        perr0_n  = 1'b0;
        perr1_n  = 1'b0;
        rdata0_n = p0_rdata;
        rdata1_n = p1_rdata;
        adr_n    = md_adr;
        din_n    = md_din;
        w_n      = md_w;
        r_n      = md_r;
        case (state)
            S_IDLE: begin
                if (p0_req | p1_req) begin
                    sel_n   = pick_c;
                    last_n  = pick_c;
                    we_n    = pick_we_c;
                    err_n   = ~in_range_c;
                    gnt0_n  = ~pick_c;
                    gnt1_n  = pick_c;
                    adr_n   = pick_addr_c;
                    din_n   = pick_we_c ? pick_wdata_c : '0;
                    w_n     = in_range_c & pick_we_c;
                    r_n     = in_range_c & ~pick_we_c;
                    state_n = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_n   = 1'b0;
                r_n   = 1'b0;
                din_n = '0;
                if (sel) begin
                    valid1_n = 1'b1;
                    perr1_n  = err_q;
                    rdata1_n = cap_c;
                end else begin
                    valid0_n = 1'b1;
                    perr0_n  = err_q;
                    rdata0_n = cap_c;
                end
                state_n = S_RESP;
            end
            S_RESP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                w_n     = 1'b0;
                r_n     = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset kills any in-flight access at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            last     <= 1'b1;
            sel      <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            p0_gnt   <= 1'b0;
            p1_gnt   <= 1'b0;
            p0_valid <= 1'b0;
            p1_valid <= 1'b0;
            p0_err   <= 1'b0;
            p1_err   <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
            md_adr   <= '0;
            md_din   <= '0;
            md_w     <= 1'b0;
            md_r     <= 1'b0;
        end else begin
            state    <= state_n;
            last     <= last_n;
            sel      <= sel_n;
            we_q     <= we_n;
            err_q    <= err_n;
            p0_gnt   <= gnt0_n;
            p1_gnt   <= gnt1_n;
            p0_valid <= valid0_n;
            p1_valid <= valid1_n;
            p0_err   <= perr0_n;
            p1_err   <= perr1_n;
            p0_rdata <= rdata0_n;
            p1_rdata <= rdata1_n;
            md_adr   <= adr_n;
            md_din   <= din_n;
            md_w     <= w_n;
            md_r     <= r_n;
        end
    end

endmodule

// File: tb/tb_md_arbiter.sv
// Bench for md_arbiter: transaction-level reference model, per-cycle compare,
// directed scenarios and randomized two-port traffic against a memory model.
module tb_md_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic load  = 1'b1;

    logic        req_v   [2];
    logic        we_v    [2];
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];

    logic        p0_gnt, p0_valid, p0_err, p1_gnt, p1_valid, p1_err;
    logic [31:0] p0_rdata, p1_rdata, md_adr, md_din, md_dout;
    logic        md_w, md_r;

    md_arbiter #(.DEPTH(128), .AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(req_v[0]), .p0_we(we_v[0]), .p0_addr(addr_v[0]), .p0_wdata(wdata_v[0]),
        .p0_gnt(p0_gnt), .p0_valid(p0_valid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(req_v[1]), .p1_we(we_v[1]), .p1_addr(addr_v[1]), .p1_wdata(wdata_v[1]),
        .p1_gnt(p1_gnt), .p1_valid(p1_valid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .md_adr(md_adr), .md_din(md_din), .md_w(md_w), .md_r(md_r), .md_dout(md_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input int i);
        return 32'(i) * 32'h9E37_79B9 + 32'h0BAD_F00D;
    endfunction

    // Memory attached to the DUT: combinational read, write on the edge ending ACCESS.
    logic [31:0] mem [128];
    assign md_dout = (md_adr < 32'd128) ? mem[md_adr[6:0]] : 32'hBAD0_BAD0;
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
        end else if (md_w && md_adr < 32'd128) begin
            mem[md_adr[6:0]] <= md_din;
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    endtask

    // Reference model: one transaction at a time, three cycles each.
    logic        e_gnt [2] = '{1'b0, 1'b0};
    logic        e_valid [2] = '{1'b0, 1'b0};
    logic        e_err [2] = '{1'b0, 1'b0};
    logic [31:0] e_rdata [2] = '{32'd0, 32'd0};
    logic [31:0] e_adr = '0, e_din = '0;
    logic        e_w = 1'b0, e_r = 1'b0;
    logic [31:0] ref_mem [128];
    int          m_phase = 0, m_port = 0, m_last = 1;
    logic        m_we, m_inr;
    logic [31:0] m_addr, m_wd;

    always @(posedge clk or negedge rst_n) begin
        if (load) for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
        if (!rst_n) begin
            m_phase = 0; m_last = 1;
            e_gnt = '{1'b0, 1'b0}; e_valid = '{1'b0, 1'b0}; e_err = '{1'b0, 1'b0};
            e_rdata = '{32'd0, 32'd0};
            e_adr = '0; e_din = '0; e_w = 1'b0; e_r = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    e_valid = '{1'b0, 1'b0}; e_err = '{1'b0, 1'b0};
                    if (req_v[0] || req_v[1]) begin
                        m_port = (req_v[0] && req_v[1]) ? 1 - m_last : (req_v[1] ? 1 : 0);
                        m_last = m_port;
                        m_we = we_v[m_port]; m_addr = addr_v[m_port]; m_wd = wdata_v[m_port];
                        m_inr = m_addr < 32'd128;
                        e_gnt[m_port] = 1'b1;
                        e_adr = m_addr;
                        e_din = m_we ? m_wd : 32'd0;
                        e_w = m_we && m_inr;
                        e_r = !m_we && m_inr;
                        m_phase = 1;
                    end
                end
                1: begin
                    e_gnt = '{1'b0, 1'b0};
                    e_w = 1'b0; e_r = 1'b0; e_din = '0;
                    e_valid[m_port] = 1'b1;
                    e_err[m_port] = !m_inr;
                    e_rdata[m_port] = (!m_we && m_inr) ? ref_mem[m_addr[6:0]] : 32'd0;
                    if (m_we && m_inr) ref_mem[m_addr[6:0]] = m_wd;
                    m_phase = 2;
                end
                default: begin
                    e_valid = '{1'b0, 1'b0}; e_err = '{1'b0, 1'b0};
                    m_phase = 0;
                end
            endcase
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        chk("p0_gnt",   32'(p0_gnt),   32'(e_gnt[0]));
        chk("p1_gnt",   32'(p1_gnt),   32'(e_gnt[1]));
        chk("p0_valid", 32'(p0_valid), 32'(e_valid[0]));
        chk("p1_valid", 32'(p1_valid), 32'(e_valid[1]));
        chk("p0_err",   32'(p0_err),   32'(e_err[0]));
        chk("p1_err",   32'(p1_err),   32'(e_err[1]));
        chk("p0_rdata", p0_rdata, e_rdata[0]);
        chk("p1_rdata", p1_rdata, e_rdata[1]);
        chk("md_adr",   md_adr,   e_adr);
        chk("md_din",   md_din,   e_din);
        chk("md_w",     32'(md_w), 32'(e_w));
        chk("md_r",     32'(md_r), 32'(e_r));
        chk("w_r_excl", 32'(md_w & md_r), 32'd0);
        chk("valid_excl", 32'(p0_valid & p1_valid), 32'd0);
    end

    function automatic logic gnt_of(input int p);
        return (p != 0) ? p1_gnt : p0_gnt;
    endfunction

    function automatic logic valid_of(input int p);
        return (p != 0) ? p1_valid : p0_valid;
    endfunction

    // One requester transaction with the hold-until-grant handshake.
    task automatic txn(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       output int gc, output int vc, output logic ow, output logic orr,
                       output logic [31:0] oadr, output logic [31:0] ord, output logic oerr);
        gc = -1; vc = -1; ow = 1'b0; orr = 1'b0; oadr = '0; ord = '0; oerr = 1'b0;
        @(negedge clk);
        req_v[p] = 1'b1; we_v[p] = we; addr_v[p] = addr; wdata_v[p] = wd;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (gnt_of(p)) begin
                gc = cyc; ow = md_w; orr = md_r; oadr = md_adr;
                break;
            end
        end
        req_v[p] = 1'b0;
        chk("gnt_seen", 32'(gc >= 0), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (valid_of(p)) begin
                vc = cyc; ord = (p != 0) ? p1_rdata : p0_rdata; oerr = (p != 0) ? p1_err : p0_err;
                break;
            end
        end
        chk("valid_seen", 32'(vc >= 0), 32'd1);
    endtask

    task automatic rand_txn(input int p);
        int gc, vc;
        logic ow, orr, oerr;
        logic [31:0] oadr, ord, a;
        int sel;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        sel = int'($urandom_range(0, 9));
        if (sel < 8) a = 32'($urandom_range(0, 15));
        else if (sel == 8) a = 32'd128 + 32'($urandom_range(0, 15));
        else a = $urandom;
        txn(p, 1'($urandom_range(0, 1)), a, $urandom, gc, vc, ow, orr, oadr, ord, oerr);
    endtask

    int gc0, vc0, gc1, vc1, cnt_g, cnt_v, k;
    logic ow0, or0, oe0, ow1, or1, oe1;
    logic [31:0] oa0, od0, oa1, od1;
    int gord[$];

    initial begin
        for (int p = 0; p < 2; p++) begin
            req_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = '0; wdata_v[p] = '0;
        end
        repeat (3) @(negedge clk);
        load = 1'b0;
        chk("rst_p0_gnt", 32'(p0_gnt), 32'd0);
        chk("rst_md_w", 32'(md_w), 32'd0);
        chk("rst_md_adr", md_adr, 32'd0);
        chk("rst_p1_rdata", p1_rdata, 32'd0);
        #2 rst_n = 1'b1;

        // Write then read back address 5.
        txn(0, 1'b1, 32'd5, 32'hDEAD_BEEF, gc0, vc0, ow0, or0, oa0, od0, oe0);
        chk("wr_md_w", 32'(ow0), 32'd1);
        chk("wr_md_r", 32'(or0), 32'd0);
        chk("wr_md_adr", oa0, 32'd5);
        chk("wr_latency", 32'(vc0 - gc0), 32'd1);
        chk("wr_err", 32'(oe0), 32'd0);
        txn(0, 1'b0, 32'd5, 32'h0, gc0, vc0, ow0, or0, oa0, od0, oe0);
        chk("rd_md_r", 32'(or0), 32'd1);
        chk("rd_data", od0, 32'hDEAD_BEEF);

        // Out-of-range write whose low bits alias address 5 must not land.
        txn(0, 1'b1, 32'd133, 32'h0BAD_0BAD, gc0, vc0, ow0, or0, oa0, od0, oe0);
        chk("oor_wr_w", 32'(ow0), 32'd0);
        chk("oor_wr_adr", oa0, 32'd133);
        chk("oor_wr_err", 32'(oe0), 32'd1);
        txn(0, 1'b0, 32'd5, 32'h0, gc0, vc0, ow0, or0, oa0, od0, oe0);
        chk("rd5_after_oor", od0, 32'hDEAD_BEEF);

        // Fresh reset, then simultaneous reads: port 0 wins the tie.
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        fork
            txn(0, 1'b0, 32'd1, 32'h0, gc0, vc0, ow0, or0, oa0, od0, oe0);
            txn(1, 1'b0, 32'd2, 32'h0, gc1, vc1, ow1, or1, oa1, od1, oe1);
        join
        chk("tie_gap", 32'(gc1 - gc0), 32'd3);
        chk("tie_rd1", od0, init_val(1));
        chk("tie_rd2", od1, init_val(2));

        // Both requests held: grants alternate 0,1,0,1.
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 32'd10;
        req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 32'd11;
        repeat (12) begin
            @(negedge clk);
            if (p0_gnt) gord.push_back(0);
            if (p1_gnt) gord.push_back(1);
        end
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("alt_count", 32'(gord.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("alt_order", 32'((i < gord.size()) ? gord[i] : 9), 32'(i % 2));

        // Port 1 out-of-range read.
        txn(1, 1'b0, 32'd200, 32'h0, gc1, vc1, ow1, or1, oa1, od1, oe1);
        chk("oor_rd_w", 32'(ow1), 32'd0);
        chk("oor_rd_r", 32'(or1), 32'd0);
        chk("oor_rd_err", 32'(oe1), 32'd1);
        chk("oor_rd_data", od1, 32'd0);

        // Reset asserted mid-ACCESS of a write.
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'd7; wdata_v[0] = 32'h1234_5678;
        k = 0;
        while (!p0_gnt && k < 10) begin @(negedge clk); k++; end
        chk("abort_gnt_seen", 32'(p0_gnt), 32'd1);
        chk("abort_w_before", 32'(md_w), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_md_w", 32'(md_w), 32'd0);
        chk("abort_gnt", 32'(p0_gnt), 32'd0);
        chk("abort_valid", 32'(p0_valid), 32'd0);
        chk("abort_adr", md_adr, 32'd0);
        req_v[0] = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_mem7", mem[7], init_val(7));
        txn(1, 1'b0, 32'd7, 32'h0, gc1, vc1, ow1, or1, oa1, od1, oe1);
        chk("post_rst_p1_rd7", od1, init_val(7));

        // Port 1 held for 9 cycles alone: exactly three transactions.
        @(negedge clk);
        req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 32'd3;
        cnt_g = 0; cnt_v = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 8) req_v[1] = 1'b0;
            if (p1_gnt) cnt_g++;
            if (p1_valid) cnt_v++;
        end
        chk("held9_gnts", 32'(cnt_g), 32'd3);
        chk("held9_valids", 32'(cnt_v), 32'd3);

        // Randomized concurrent traffic.
        fork
            begin for (int i = 0; i < 30; i++) rand_txn(0); end
            begin for (int i = 0; i < 30; i++) rand_txn(1); end
        join
        repeat (5) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
